gait_sequencer: RTL and testbench
=================================

// Module: gait_sequencer
// PURPOSE
//  Sequences the three-leg walking gait for the line follower. Replaces free-running step
//  counter, init timer and ad-hoc leg enables with one FSM: waits out servo calibration,
//  generates the ROM step address, and gates per-leg servo enables from the debounced IR
//  sensors. Sits between the IR debouncers and the leg ROMs/servopwm instances.
// PARAMETERS
//  STEP_DIV      200_000     clk cycles per gait step (ROM address advance)
//  CALIB_CYCLES  80_000_000  clk cycles held in CALIB after reset before walking
//  ADDR_W        8           width of ROM step address
//  GAIT_LEN      256         steps per gait cycle; addr wraps GAIT_LEN-1 -> 0 (<= 2**ADDR_W)
//  LOST_STEPS    64          consecutive steps with both sensors on line before HALT
// PORTS
//  clk     in   1       system clock
//  rst     in   1       synchronous reset, active-high
//  l_ir    in   1       debounced left IR; 1 = background under sensor, 0 = line
//  r_ir    in   1       debounced right IR; same encoding
//  addr    out  ADDR_W  gait ROM address, shared by all three leg ROMs
//  step    out  1       one-cycle pulse in the cycle addr advances
//  l_en    out  1       left leg servo enable_mov
//  r_en    out  1       right leg servo enable_mov
//  c_en    out  1       centre leg servo enable_mov
//  state   out  3       FSM state code, for LED debug
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. All outputs registered.
//  - Reset values: state=CALIB(0), addr=0, step=0, l_en=r_en=c_en=0; prescaler, calib and
//    lost counters = 0. rst asserted mid-operation aborts any state identically.
//  - States/codes: CALIB=0, FWD=1, TURN_L=2, TURN_R=3, LOST=4, HALT=5. Codes 6,7 -> CALIB.
//  - CALIB: calib counter increments each cycle; in cycle it equals CALIB_CYCLES-1, state
//    -> FWD next cycle. Prescaler held at 0, no step pulses, all enables 0.
//  - Prescaler: runs in FWD/TURN_L/TURN_R/LOST, counts 0..STEP_DIV-1; step=1 for the one
//    cycle after prescaler==STEP_DIV-1, same cycle addr increments (wrap at GAIT_LEN-1).
//  - State changes and enable updates occur only on step cycles (gait phases never torn).
//    On a step, sensors sampled that cycle select next state:
//      l_ir=1,r_ir=1 -> FWD;  l_ir=0,r_ir=1 -> TURN_L;  l_ir=1,r_ir=0 -> TURN_R;
//      l_ir=0,r_ir=0 -> LOST (lost counter +1 per step while staying LOST).
//  - Enables by state: FWD l=1 r=1 c=1; TURN_L l=0 r=1 c=1; TURN_R l=1 r=0 c=1;
//    LOST l=1 r=1 c=1 (keep walking to search); CALIB/HALT all 0.
//  - Sensor-to-enable latency: at most STEP_DIV+1 cycles.
//  - LOST: on a step with both sensors 0 and lost counter == LOST_STEPS-1 -> HALT.
//    Any sensor 1 on a step leaves LOST per table above; lost counter cleared on any exit.
//  - HALT: addr frozen, step=0, enables 0; exit only via rst.
//  - Sensor glitches between steps have no effect (sampled only on step cycles).
// TESTING  (STEP_DIV=4, CALIB_CYCLES=10, GAIT_LEN=8, LOST_STEPS=3, ADDR_W=8)
//  1 rst 2 cycles, sensors 1/1 -> state=0, enables 0 for 10 cycles, then state=1; first
//    step 4 cycles later with addr=1, l/r/c_en=1.
//  2 Walk 8 steps in FWD -> addr 1..7,0,1 (wrap at 7), step pulses exactly every 4 cycles.
//  3 In FWD drop l_ir=0 -> at next step state=2, l_en=0 r_en=1; restore -> next step FWD.
//  4 Toggle r_ir for 2 cycles strictly between steps -> no state/enable change.
//  5 Both sensors 0 for 3 steps -> state 4,4, then 5; addr frozen, enables 0 for 50 cycles.
//  6 rst pulse while in TURN_R mid-prescale -> next cycle state=0, addr=0, enables 0.

Source files
------------

// File: rtl/gait_sequencer.sv
// -----------------------------------------------------------------------------
// gait_sequencer
//   Sequences the three-leg walking gait of the line follower. After reset it
//   waits out servo calibration. It then produces the shared leg-ROM step
//   address and gates the per-leg servo enables from the debounced IR sensors.
//
//   Handshake / timing contract (no valid/ready here; all outputs registered):
//   the prescaler wraps once every STEP_DIV cycles. That wrap edge drives
//   "step" high for exactly one cycle and advances "addr". The same edge
//   samples l_ir/r_ir and loads the next state and the enables. State and
//   enables therefore change only together with a step pulse, and sensor
//   activity between steps is ignored.
//
// Ports
//   clk    in   1       system clock
//   rst    in   1       synchronous reset, active-high
//   l_ir   in   1       debounced left IR  (1 = background, 0 = line)
//   r_ir   in   1       debounced right IR (same encoding)
//   addr   out  ADDR_W  gait ROM address shared by all three leg ROMs
//   step   out  1       one-cycle pulse in the cycle addr advances
//   l_en   out  1       left leg servo enable
//   r_en   out  1       right leg servo enable
//   c_en   out  1       centre leg servo enable
//   state  out  3       FSM state code (debug / LEDs)
// -----------------------------------------------------------------------------
module gait_sequencer #(
   parameter int STEP_DIV     = 200_000,
   parameter int CALIB_CYCLES = 80_000_000,
   parameter int ADDR_W       = 8,
   parameter int GAIT_LEN     = 256,
   parameter int LOST_STEPS   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              l_ir,
   input  logic              r_ir,
   output logic [ADDR_W-1:0] addr,
   output logic              step,
   output logic              l_en,
   output logic              r_en,
   output logic              c_en,
   output logic [2:0]        state
);

   localparam int PRESC_W = (STEP_DIV     > 1) ? $clog2(STEP_DIV)     : 1;
   localparam int CALIB_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
   localparam int LOST_W  = (LOST_STEPS   > 1) ? $clog2(LOST_STEPS)   : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
   localparam logic [CALIB_W-1:0] CALIB_LAST = CALIB_W'(CALIB_CYCLES - 1);
   localparam logic [LOST_W-1:0]  LOST_LAST  = LOST_W'(LOST_STEPS - 1);
   localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(GAIT_LEN - 1);

   typedef enum logic [2:0] {
      S_CALIB  = 3'd0,
      S_FWD    = 3'd1,
      S_TURN_L = 3'd2,
      S_TURN_R = 3'd3,
      S_LOST   = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t              r_state;
   logic [PRESC_W-1:0]  r_presc;
   logic [CALIB_W-1:0]  r_calib;
   logic [LOST_W-1:0]   r_lost;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_step;
   logic                r_l_en;
   logic                r_r_en;
   logic                r_c_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_CALIB;
         r_presc <= '0;
         r_calib <= '0;
         r_lost  <= '0;
         r_addr  <= '0;
         r_step  <= 1'b0;
         r_l_en  <= 1'b0;
         r_r_en  <= 1'b0;
         r_c_en  <= 1'b0;
      end else begin
         r_step <= 1'b0;
         case (r_state)
            S_CALIB: begin
               r_presc <= '0;
               r_l_en  <= 1'b0;
               r_r_en  <= 1'b0;
               r_c_en  <= 1'b0;
               if (r_calib == CALIB_LAST) begin
                  r_calib <= '0;
                  r_state <= S_FWD;
               end else begin
                  r_calib <= r_calib + 1'b1;
               end
            end

            S_FWD, S_TURN_L, S_TURN_R, S_LOST: begin
               if (r_presc == PRESC_LAST) begin
                  // Step edge: pulse, advance address and re-decide the gait.
                  // The step that enters HALT is still a full step, so it
                  // pulses and advances addr; HALT freezes from then on.
                  r_presc <= '0;
                  r_step  <= 1'b1;
                  r_addr  <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
                  case ({l_ir, r_ir})
                     2'b11: begin
                        r_state <= S_FWD;
                        r_lost  <= '0;
                        {r_l_en, r_r_en, r_c_en} <= 3'b111;
                     end
                     2'b01: begin
                        r_state <= S_TURN_L;
                        r_lost  <= '0;
                        {r_l_en, r_r_en, r_c_en} <= 3'b011;
                     end
                     2'b10: begin
                        r_state <= S_TURN_R;
                        r_lost  <= '0;
                        {r_l_en, r_r_en, r_c_en} <= 3'b101;
                     end
                     default: begin
                        // The lost counter counts line-less steps including the
                        // one that enters LOST (it is 0 in every other state).
                        if (r_lost == LOST_LAST) begin
                           r_state <= S_HALT;
                           r_lost  <= '0;
                           {r_l_en, r_r_en, r_c_en} <= 3'b000;
                        end else begin
                           r_state <= S_LOST;
                           r_lost  <= r_lost + 1'b1;
                           {r_l_en, r_r_en, r_c_en} <= 3'b111;
                        end
                     end
                  endcase
               end else begin
                  r_presc <= r_presc + 1'b1;
               end
            end

            S_HALT: begin
               r_presc <= '0;
               r_l_en  <= 1'b0;
               r_r_en  <= 1'b0;
               r_c_en  <= 1'b0;
            end

            default: begin
               // Unused codes recover into calibration.
               r_state <= S_CALIB;
               r_presc <= '0;
               r_calib <= '0;
               r_lost  <= '0;
               r_l_en  <= 1'b0;
               r_r_en  <= 1'b0;
               r_c_en  <= 1'b0;
            end
         endcase
      end
   end

   assign addr  = r_addr;
   assign step  = r_step;
   assign l_en  = r_l_en;
   assign r_en  = r_r_en;
   assign c_en  = r_c_en;
   assign state = r_state;

endmodule

// File: tb/tb_gait_sequencer.sv
module tb_gait_sequencer;

  localparam int STEP_DIV     = 4;
  localparam int CALIB_CYCLES = 10;
  localparam int ADDR_W       = 8;
  localparam int GAIT_LEN     = 8;
  localparam int LOST_STEPS   = 3;
  localparam int W            = 3 + ADDR_W + 3;

  localparam logic [2:0] ST_CALIB = 3'd0;
  localparam logic [2:0] ST_FWD   = 3'd1;
  localparam logic [2:0] ST_TL    = 3'd2;
  localparam logic [2:0] ST_TR    = 3'd3;
  localparam logic [2:0] ST_LOST  = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  logic              clk;
  logic              rst;
  logic              l_ir;
  logic              r_ir;
  logic [ADDR_W-1:0] addr;
  logic              step;
  logic              l_en;
  logic              r_en;
  logic              c_en;
  logic [2:0]        state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] frozen_addr;

  gait_sequencer #(
    .STEP_DIV     (STEP_DIV),
    .CALIB_CYCLES (CALIB_CYCLES),
    .ADDR_W       (ADDR_W),
    .GAIT_LEN     (GAIT_LEN),
    .LOST_STEPS   (LOST_STEPS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .l_ir  (l_ir),
    .r_ir  (r_ir),
    .addr  (addr),
    .step  (step),
    .l_en  (l_en),
    .r_en  (r_en),
    .c_en  (c_en),
    .state (state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {state, addr, l_en, r_en, c_en};
  endfunction

  // Push the expected outcome of the next step: addr advances (wrapping).
  task automatic push_exp(input logic [2:0] st, input logic [2:0] en);
    m_addr = (m_addr == ADDR_W'(GAIT_LEN - 1)) ? '0 : m_addr + 1'b1;
    exp_q.push_back({st, m_addr, en});
  endtask

  // Wait (bounded) for the next step pulse, check its latency and pop/compare.
  task automatic wait_step(input int exp_cycles, input string tag);
    int n;
    logic [W-1:0] e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!step && n < 20);
    check({tag, " step latency"}, n, exp_cycles);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " state/addr/en"}, observed(), e);
    end else begin
      check({tag, " scoreboard empty"}, 1, 0);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
    m_addr = '0;
    check("reset outputs", {observed(), step}, {ST_CALIB, {ADDR_W{1'b0}}, 3'b000, 1'b0});
  endtask

  // CALIB lasts CALIB_CYCLES cycles counting the first cycle after reset.
  task automatic run_calib();
    for (int i = 1; i < CALIB_CYCLES; i++) begin
      tick();
      check("calib hold", {state, l_en, r_en, c_en, step}, {ST_CALIB, 4'b0000});
    end
    tick();
    check("calib exit", {state, l_en, r_en, c_en, step}, {ST_FWD, 4'b0000});
  endtask

  initial begin
    rst  = 1'b1;
    l_ir = 1'b1;
    r_ir = 1'b1;
    m_addr = '0;

    // 1: reset, calibration, first step
    do_reset(2);
    run_calib();
    push_exp(ST_FWD, 3'b111);
    wait_step(STEP_DIV, "first step");

    // 2: eight more FWD steps across the address wrap
    for (int i = 0; i < 8; i++) begin
      push_exp(ST_FWD, 3'b111);
      wait_step(STEP_DIV, "fwd walk");
    end

    // 3: left sensor on line -> TURN_L, then back to FWD
    l_ir = 1'b0;
    push_exp(ST_TL, 3'b011);
    wait_step(STEP_DIV, "turn left");
    l_ir = 1'b1;
    push_exp(ST_FWD, 3'b111);
    wait_step(STEP_DIV, "back to fwd");

    // 4: r_ir glitch strictly between steps is ignored
    tick();
    r_ir = 1'b0;
    check("glitch p1", {state, l_en, r_en, c_en, step}, {ST_FWD, 4'b1110});
    tick();
    check("glitch p2", {state, l_en, r_en, c_en, step}, {ST_FWD, 4'b1110});
    r_ir = 1'b1;
    tick();
    check("glitch p3", {state, l_en, r_en, c_en, step}, {ST_FWD, 4'b1110});
    push_exp(ST_FWD, 3'b111);
    wait_step(1, "after glitch");

    // lost counter clears on exit: two lost steps, recover, then full count
    l_ir = 1'b0;
    r_ir = 1'b0;
    push_exp(ST_LOST, 3'b111);
    wait_step(STEP_DIV, "lost a1");
    push_exp(ST_LOST, 3'b111);
    wait_step(STEP_DIV, "lost a2");
    l_ir = 1'b1;
    r_ir = 1'b1;
    push_exp(ST_FWD, 3'b111);
    wait_step(STEP_DIV, "lost recover");

    // 5: three line-less steps -> LOST, LOST, HALT
    l_ir = 1'b0;
    r_ir = 1'b0;
    push_exp(ST_LOST, 3'b111);
    wait_step(STEP_DIV, "lost b1");
    push_exp(ST_LOST, 3'b111);
    wait_step(STEP_DIV, "lost b2");
    push_exp(ST_HALT, 3'b000);
    wait_step(STEP_DIV, "halt entry");
    frozen_addr = m_addr;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 20) begin
        l_ir = 1'b1;
        r_ir = 1'b1;
      end
      check("halt frozen", {observed(), step}, {ST_HALT, frozen_addr, 3'b000, 1'b0});
    end

    // 6: leave HALT by reset, walk into TURN_R, reset mid-prescale
    l_ir = 1'b1;
    r_ir = 1'b0;
    do_reset(1);
    run_calib();
    push_exp(ST_TR, 3'b101);
    wait_step(STEP_DIV, "turn right");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid reset", {observed(), step}, {ST_CALIB, {ADDR_W{1'b0}}, 3'b000, 1'b0});
    rst = 1'b0;
    tick();
    check("post reset calib", {state, l_en, r_en, c_en, step}, {ST_CALIB, 4'b0000});

    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
